// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: functional-unit result requests in, registered broadcast ports out.
// The master side is the requesters/consumers, the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CDB_COUNT = 2,
    parameter int unsigned PR_BITS   = 6,
    parameter int unsigned ROB_BITS  = 5
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0][PR_BITS-1:0]     req_pr_dest;
    logic [NUM_REQ-1:0][31:0]            req_result;
    logic [NUM_REQ-1:0][ROB_BITS-1:0]    req_rob_idx;
    logic [NUM_REQ-1:0]                  req_ready;

    logic [CDB_COUNT-1:0]                cdb_valid;
    logic [CDB_COUNT-1:0][PR_BITS-1:0]   cdb_pr_dest;
    logic [CDB_COUNT-1:0][31:0]          cdb_result;
    logic [CDB_COUNT-1:0][ROB_BITS-1:0]  cdb_rob_idx;

    modport master (
        output req_valid, req_pr_dest, req_result, req_rob_idx,
        input  req_ready,
        input  cdb_valid, cdb_pr_dest, cdb_result, cdb_rob_idx
    );

    modport slave (
        input  req_valid, req_pr_dest, req_result, req_rob_idx,
        output req_ready,
        output cdb_valid, cdb_pr_dest, cdb_result, cdb_rob_idx
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to CDB_COUNT completed results per cycle onto
// registered common-data-bus broadcast ports, packed densely from port 0.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CDB_COUNT = 2,
    parameter int unsigned PR_BITS   = 6,
    parameter int unsigned ROB_BITS  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(CDB_COUNT + 1);

    typedef struct packed {
        logic [PR_BITS-1:0]  pr_dest;
        logic [31:0]         result;
        logic [ROB_BITS-1:0] rob_idx;
    } cdb_payload_t;

    logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [CDB_COUNT-1:0]              cdb_valid_q, cdb_valid_d;
    cdb_payload_t [CDB_COUNT-1:0]      payload_q, payload_d;

    logic [NUM_REQ-1:0]                valid_rot_c;
    logic [CDB_COUNT-1:0]              port_fill_c;
    logic [CDB_COUNT-1:0][PTR_W-1:0]   port_idx_c;
    logic [NUM_REQ-1:0]                grant_c;
    logic [CNT_W-1:0]                  scan_cnt_c;
    logic [SUM_W-1:0]                  scan_idx_c;

    // Bit k of the rotated vector is requester (rr_ptr + k) mod NUM_REQ.
    assign valid_rot_c = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);

    // Scan from rr_ptr, filling ports in order; the pointer follows the last grant.
    always_comb begin
        port_fill_c = '0;
        port_idx_c  = '0;
        rr_ptr_d    = rr_ptr_q;
        scan_cnt_c  = '0;
        scan_idx_c  = '0;
        if (rst && !flush) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_idx_c = SUM_W'(rr_ptr_q) + SUM_W'(k);
                if (scan_idx_c >= SUM_W'(NUM_REQ)) begin
                    scan_idx_c = scan_idx_c - SUM_W'(NUM_REQ);
                end
                if (valid_rot_c[k] && (scan_cnt_c < CNT_W'(CDB_COUNT))) begin
                    for (int unsigned p = 0; p < CDB_COUNT; p++) begin
                        if (scan_cnt_c == CNT_W'(p)) begin
                            port_fill_c[p] = 1'b1;
                            port_idx_c[p]  = PTR_W'(scan_idx_c);
                        end
                    end
                    scan_cnt_c = scan_cnt_c + CNT_W'(1);
                    rr_ptr_d   = (scan_idx_c == SUM_W'(NUM_REQ - 1)) ? '0
                                                                     : PTR_W'(scan_idx_c + SUM_W'(1));
                end
            end
        end
    end

    // Per-port payload select; unfilled ports keep their previous payload.
    always_comb begin
        grant_c     = '0;
        cdb_valid_d = port_fill_c;
        payload_d   = payload_q;
        for (int unsigned p = 0; p < CDB_COUNT; p++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (port_fill_c[p] && (port_idx_c[p] == PTR_W'(i))) begin
                    grant_c[i]           = 1'b1;
                    payload_d[p].pr_dest = bus.req_pr_dest[i];
                    payload_d[p].result  = bus.req_result[i];
                    payload_d[p].rob_idx = bus.req_rob_idx[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            payload_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            payload_q   <= payload_d;
        end
    end

    assign bus.req_ready = grant_c;

    always_comb begin
        bus.cdb_valid   = cdb_valid_q;
        bus.cdb_pr_dest = '0;
        bus.cdb_result  = '0;
        bus.cdb_rob_idx = '0;
        for (int unsigned p = 0; p < CDB_COUNT; p++) begin
            bus.cdb_pr_dest[p] = payload_q[p].pr_dest;
            bus.cdb_result[p]  = payload_q[p].result;
            bus.cdb_rob_idx[p] = payload_q[p].rob_idx;
        end
    end

endmodule
